mem_ring_controller: RTL and testbench
======================================

Name: mem_ring_controller

Overview:
- Parametrised successor of the UART-to-memory controller. It manages an external simple dual-port RAM as a circular byte buffer.
- Received UART bytes (rx_done/rx_data) are written at the write pointer.
- Bytes are read back in order, one per push_sw pulse (step mode) or on a periodic tick (auto mode). Each read value is latched onto fnd_data for the FND driver.
- Adds full/empty/occupancy status, sticky overflow, wrap-around and an explicit clear, none of which the previous fixed-depth controller had.

Parameters:
- D_WIDTH, 8, data width of RAM words, rx_data, wdata, rdata and fnd_data.
- A_WIDTH, 3, RAM address width.
- DEPTH, 8, usable buffer entries; legal range 2..2**A_WIDTH.
- AUTO_PERIOD, 50000000, clocks between auto-mode read ticks; must be >= 4.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- rx_done  in  1  one-cycle pulse: rx_data valid.
- rx_data  in  D_WIDTH  received byte.
- push_sw  in  1  debounced one-cycle pulse: step-read request.
- mode_sw  in  1  0 = step mode, 1 = auto mode; level input.
- clr_sw  in  1  one-cycle pulse: clear buffer.
- waddr  out  A_WIDTH  RAM write address.
- wen  out  1  RAM write enable.
- wdata  out  D_WIDTH  RAM write data.
- raddr  out  A_WIDTH  RAM read address.
- ren  out  1  RAM read enable.
- rdata  in  D_WIDTH  RAM read data, valid one cycle after ren.
- fnd_data  out  D_WIDTH  last byte read.
- count  out  A_WIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a byte was dropped because the buffer was full.

Behaviour:
- Reset: all registered outputs 0. Pointers 0, count 0, empty=1, full=0, overflow=0, read FSM in R_IDLE, tick counter 0.
- Write path:
  - On the edge sampling rx_done=1 with count<DEPTH, or with count==DEPTH and a read being issued on the same edge: wen<=1, wdata<=rx_data, count incremented.
  - waddr holds for the cycle wen is high. waddr advances on the edge that ends wen, wrapping DEPTH-1 -> 0.
  - rx_done=1 while full with no same-edge read: byte dropped, overflow<=1, wen stays 0.
- Read FSM has three states: R_IDLE, R_ISSUE, R_CAPTURE.
  - R_IDLE -> R_ISSUE when a read request is present and count>0. ren<=1 and count is decremented on that edge.
  - A read request is push_sw=1 when mode_sw=0, or tick=1 when mode_sw=1.
  - In R_ISSUE, ren=1 and raddr is valid. The next edge goes to R_CAPTURE with ren<=0 and raddr advancing, wrapping DEPTH-1 -> 0.
  - In R_CAPTURE, fnd_data<=rdata. The next edge goes to R_IDLE.
  - Read latency: fnd_data updates 2 edges after the request is sampled.
  - Requests arriving in R_ISSUE/R_CAPTURE, or while empty, are dropped, not queued.
  - fnd_data holds its value otherwise.
- Tick:
  - The tick counter runs only while mode_sw=1 and resets to 0 whenever mode_sw=0.
  - tick is a one-cycle pulse when the counter reaches AUTO_PERIOD-1; the counter wraps to 0.
  - push_sw is ignored in auto mode.
- Simultaneous accepted write and read on one edge: count unchanged; full and empty are derived from the next count.
- Clear (clr_sw=1) has priority over all events on that edge:
  - pointers, count, overflow and fnd_data go to 0;
  - wen/ren go to 0 and the FSM goes to R_IDLE, aborting any in-flight read with no capture;
  - a coincident rx_done byte is dropped and does not set overflow.
- Status outputs full, empty and count are registered and consistent with each other on every cycle.
- Asynchronous reset asserted mid-operation returns everything to reset values immediately; no partial write completes.

Decomposition:
- Shared package/header: read FSM state encodings (R_IDLE=0, R_ISSUE=1, R_CAPTURE=2) and the default widths.
- One natural sub-module: auto_tick_gen (parameter AUTO_PERIOD; ports clk, n_rst, en, tick), reusable by other display blocks.
- Pointer/count logic and the FSM stay in the top module.

Test Plan:
- DEPTH=8, AUTO_PERIOD=4, step mode:
  - rx bytes 0x11, 0x22, 0x33 -> wen pulses at waddr 0, 1, 2; count=3. Three push_sw pulses -> fnd_data 0x11, 0x22, 0x33, each 2 cycles after its push; empty=1.
  - Write 10 bytes 0x00..0x09 with no reads -> full=1 after the 8th; overflow=1 after the 9th. Eight reads return 0x00..0x07.
  - Write 6 bytes, read 6, write 4 more -> waddr wraps 7 -> 0. Reads return the 4 new bytes in order; raddr wraps 7 -> 0.
  - Full buffer, rx_done and push_sw on the same edge -> read issued, byte accepted, count stays 8, overflow stays 0.
- Auto mode, mode_sw=1 with 3 bytes stored -> fnd_data advances every 4 cycles, then holds once empty. mode_sw=0 stops reads; pushes work again.
- clr_sw during R_ISSUE, with count=5 and overflow=1 -> next cycle count=0, empty=1, overflow=0, fnd_data=0, ren=0, no capture. A push after the clear is ignored.

Source files
------------

// File: rtl/mem_ring_controller_pkg.sv
// Shared definitions for the ring-buffer memory controller: read FSM
// encodings and the default widths and timing used by the blocks.
package mem_ring_controller_pkg;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_ISSUE   = 2'd1,
    R_CAPTURE = 2'd2
  } rstate_t;

  localparam int DEF_D_WIDTH     = 8;
  localparam int DEF_A_WIDTH     = 3;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_AUTO_PERIOD = 50000000;

endpackage

// File: rtl/auto_tick_gen.sv
// Periodic one-cycle tick generator. The counter only runs while en is
// high and restarts from zero each time en drops, so the first tick comes
// a full period after enabling.
module auto_tick_gen
  import mem_ring_controller_pkg::*;
#(
  parameter int AUTO_PERIOD = DEF_AUTO_PERIOD
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(AUTO_PERIOD - 1);

  logic [CW-1:0] cnt;

  // Free-running period counter, held at zero while disabled.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (!en || (cnt == LAST_CNT)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST_CNT);

endmodule

// File: rtl/mem_ring_controller.sv
// Circular byte buffer controller over an external simple dual-port RAM.
// UART bytes are written at the write pointer; bytes are read back in order
// (on push_sw in step mode, on a periodic tick in auto mode) and the last
// one read is held on fnd_data.
module mem_ring_controller
  import mem_ring_controller_pkg::*;
#(
  parameter int D_WIDTH     = DEF_D_WIDTH,
  parameter int A_WIDTH     = DEF_A_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int AUTO_PERIOD = DEF_AUTO_PERIOD
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               rx_done,
  input  logic [D_WIDTH-1:0] rx_data,
  input  logic               push_sw,
  input  logic               mode_sw,
  input  logic               clr_sw,
  output logic [A_WIDTH-1:0] waddr,
  output logic               wen,
  output logic [D_WIDTH-1:0] wdata,
  output logic [A_WIDTH-1:0] raddr,
  output logic               ren,
  input  logic [D_WIDTH-1:0] rdata,
  output logic [D_WIDTH-1:0] fnd_data,
  output logic [A_WIDTH:0]   count,
  output logic               full,
  output logic               empty,
  output logic               overflow
);

  localparam logic [A_WIDTH:0]   FULL_CNT = (A_WIDTH + 1)'(DEPTH);
  localparam logic [A_WIDTH-1:0] LAST_PTR = A_WIDTH'(DEPTH - 1);

  // Pointer increment that wraps at the usable depth, not the RAM size.
  function automatic logic [A_WIDTH-1:0] ptr_inc(input logic [A_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + A_WIDTH'(1);
  endfunction

  rstate_t             state, state_nxt;
  logic                tick;
  logic                rd_req;
  logic                rd_issue;
  logic                wr_accept;
  logic [A_WIDTH:0]    count_nxt;

  auto_tick_gen #(
    .AUTO_PERIOD(AUTO_PERIOD)
  ) u_tick (
    .clk  (clk),
    .n_rst(n_rst),
    .en   (mode_sw),
    .tick (tick)
  );

  // Event decode: a read issued on the same edge frees the slot that a
  // write into a full buffer needs, so that write is accepted too.
  always_comb begin
    rd_req    = mode_sw ? tick : push_sw;
    rd_issue  = (state == R_IDLE) && rd_req && (count != '0) && !clr_sw;
    wr_accept = rx_done && !clr_sw && ((count != FULL_CNT) || rd_issue);
    count_nxt = count;
    if (wr_accept && !rd_issue) begin
      count_nxt = count + (A_WIDTH + 1)'(1);
    end else if (rd_issue && !wr_accept) begin
      count_nxt = count - (A_WIDTH + 1)'(1);
    end
    state_nxt = state;
    case (state)
      R_IDLE:    if (rd_issue) state_nxt = R_ISSUE;
      R_ISSUE:   state_nxt = R_CAPTURE;
      R_CAPTURE: state_nxt = R_IDLE;
      default:   state_nxt = R_IDLE;
    endcase
    if (clr_sw) begin
      state_nxt = R_IDLE;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= R_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign ren = (state == R_ISSUE);

  // Write port: waddr advances on the edge that closes each write cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      waddr    <= '0;
      wen      <= 1'b0;
      wdata    <= '0;
      overflow <= 1'b0;
    end else if (clr_sw) begin
      waddr    <= '0;
      wen      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wen) begin
        waddr <= ptr_inc(waddr);
      end
      wen <= wr_accept;
      if (wr_accept) begin
        wdata <= rx_data;
      end
      if (rx_done && !wr_accept) begin
        overflow <= 1'b1;
      end
    end
  end

  // Read port: raddr advances leaving R_ISSUE, RAM data captured leaving R_CAPTURE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      raddr    <= '0;
      fnd_data <= '0;
    end else if (clr_sw) begin
      raddr    <= '0;
      fnd_data <= '0;
    end else begin
      if (state == R_ISSUE) begin
        raddr <= ptr_inc(raddr);
      end
      if (state == R_CAPTURE) begin
        fnd_data <= rdata;
      end
    end
  end

  // Occupancy and flags, all derived from the same next count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else if (clr_sw) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

endmodule

// File: tb/tb_mem_ring_controller.sv
// Directed bench for mem_ring_controller with DEPTH=8 and AUTO_PERIOD=4,
// including a behavioural model of the external dual-port RAM.
module tb_mem_ring_controller;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_done, push_sw, mode_sw, clr_sw;
  logic [7:0] rx_data;
  logic [2:0] waddr, raddr;
  logic       wen, ren;
  logic [7:0] wdata, rdata, fnd_data;
  logic [3:0] count;
  logic       full, empty, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] last_fnd = 8'h00;

  mem_ring_controller #(
    .D_WIDTH(8), .A_WIDTH(3), .DEPTH(8), .AUTO_PERIOD(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .rx_done(rx_done), .rx_data(rx_data),
    .push_sw(push_sw), .mode_sw(mode_sw), .clr_sw(clr_sw),
    .waddr(waddr), .wen(wen), .wdata(wdata), .raddr(raddr), .ren(ren),
    .rdata(rdata), .fnd_data(fnd_data), .count(count), .full(full),
    .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // External RAM: synchronous write, registered read one cycle after ren.
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1; rx_data = b;
    step(1);
    rx_done = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_sw = 1'b1;
    step(1);
    clr_sw = 1'b0;
    last_fnd = 8'h00;
  endtask

  task automatic do_read(input logic [7:0] exp_d, input logic [2:0] exp_ra);
    push_sw = 1'b1;
    step(1);
    push_sw = 1'b0;
    chk("rd_ren", 32'(ren), 1);
    chk("rd_raddr", 32'(raddr), 32'(exp_ra));
    step(1);
    chk("rd_ren_off", 32'(ren), 0);
    chk("rd_latency", 32'(fnd_data), 32'(last_fnd));
    step(1);
    chk("rd_data", 32'(fnd_data), 32'(exp_d));
    last_fnd = exp_d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    push_sw = 1'b0; mode_sw = 1'b0; clr_sw = 1'b0;
    #23 n_rst = 1'b1;
    step(1);

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_ren", 32'(ren), 0);
    chk("rst_fnd", 32'(fnd_data), 0);

    // Basic write of three bytes, then three step reads
    send_byte(8'h11);
    chk("w1_wen", 32'(wen), 1);
    chk("w1_waddr", 32'(waddr), 0);
    chk("w1_wdata", 32'(wdata), 32'h11);
    chk("w1_empty", 32'(empty), 0);
    send_byte(8'h22);
    chk("w2_waddr", 32'(waddr), 1);
    chk("w2_wdata", 32'(wdata), 32'h22);
    send_byte(8'h33);
    chk("w3_waddr", 32'(waddr), 2);
    step(1);
    chk("w_idle_wen", 32'(wen), 0);
    chk("w_idle_waddr", 32'(waddr), 3);
    chk("w_count3", 32'(count), 3);
    do_read(8'h11, 3'd0);
    do_read(8'h22, 3'd1);
    do_read(8'h33, 3'd2);
    chk("basic_empty", 32'(empty), 1);
    chk("basic_count", 32'(count), 0);

    // Fill to full, then overflow
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(i));
      if (i == 7) begin
        chk("fill_full", 32'(full), 1);
        chk("fill_count8", 32'(count), 8);
        chk("fill_ovf_clear", 32'(overflow), 0);
      end
      if (i == 8) begin
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_wen", 32'(wen), 0);
        chk("ovf_count", 32'(count), 8);
      end
    end
    step(1);
    for (int i = 0; i < 8; i++) begin
      do_read(8'(i), 3'((3 + i) % 8));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovf_sticky", 32'(overflow), 1);

    // Clear with pointers and overflow set
    pulse_clr();
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_waddr", 32'(waddr), 0);
    chk("clr_raddr", 32'(raddr), 0);
    chk("clr_empty", 32'(empty), 1);

    // Wrap-around: write 6, read 6, write 4 across the end
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    step(1);
    for (int i = 0; i < 6; i++) do_read(8'hA0 + 8'(i), 3'(i));
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hB0 + 8'(i));
      chk("wrap_waddr", 32'(waddr), 32'((6 + i) % 8));
    end
    step(1);
    chk("wrap_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) do_read(8'hB0 + 8'(i), 3'((6 + i) % 8));
    chk("wrap_raddr_end", 32'(raddr), 2);

    // Full buffer with simultaneous write and read
    for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i));
    step(1);
    chk("sim_pre_full", 32'(full), 1);
    rx_done = 1'b1; rx_data = 8'hC8; push_sw = 1'b1;
    step(1);
    rx_done = 1'b0; push_sw = 1'b0;
    chk("sim_ren", 32'(ren), 1);
    chk("sim_wen", 32'(wen), 1);
    chk("sim_count", 32'(count), 8);
    chk("sim_full", 32'(full), 1);
    chk("sim_ovf", 32'(overflow), 0);
    step(2);
    chk("sim_data", 32'(fnd_data), 32'hC0);

    // Auto mode
    pulse_clr();
    send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
    step(1);
    mode_sw = 1'b1;
    step(4);
    chk("auto_ren", 32'(ren), 1);
    chk("auto_count", 32'(count), 2);
    step(2);
    chk("auto_d1", 32'(fnd_data), 32'hD1);
    step(4);
    chk("auto_d2", 32'(fnd_data), 32'hD2);
    step(4);
    chk("auto_d3", 32'(fnd_data), 32'hD3);
    step(8);
    chk("auto_hold", 32'(fnd_data), 32'hD3);
    chk("auto_empty", 32'(empty), 1);
    mode_sw = 1'b0;
    send_byte(8'hE1);
    step(10);
    chk("step_no_auto", 32'(count), 1);
    last_fnd = 8'hD3;
    do_read(8'hE1, 3'd3);

    // Clear during R_ISSUE with a coincident rx byte
    pulse_clr();
    for (int i = 0; i < 9; i++) send_byte(8'h50 + 8'(i));
    step(1);
    do_read(8'h50, 3'd0);
    do_read(8'h51, 3'd1);
    push_sw = 1'b1;
    step(1);
    push_sw = 1'b0;
    chk("ci_ren", 32'(ren), 1);
    chk("ci_count5", 32'(count), 5);
    chk("ci_ovf_pre", 32'(overflow), 1);
    clr_sw = 1'b1; rx_done = 1'b1; rx_data = 8'h99;
    step(1);
    clr_sw = 1'b0; rx_done = 1'b0;
    chk("ci_count", 32'(count), 0);
    chk("ci_empty", 32'(empty), 1);
    chk("ci_ovf", 32'(overflow), 0);
    chk("ci_fnd", 32'(fnd_data), 0);
    chk("ci_ren_off", 32'(ren), 0);
    chk("ci_wen", 32'(wen), 0);
    step(1);
    chk("ci_no_capture", 32'(fnd_data), 0);
    push_sw = 1'b1;
    step(1);
    push_sw = 1'b0;
    chk("ci_push_ignored", 32'(ren), 0);
    step(2);
    chk("ci_fnd_hold", 32'(fnd_data), 0);

    // Asynchronous reset in the middle of a write
    send_byte(8'h77);
    chk("ar_wen_pre", 32'(wen), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("ar_wen", 32'(wen), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_empty", 32'(empty), 1);
    #10 n_rst = 1'b1;
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
